// File: rtl/xcom_pkg.sv
// ---------------------------------------------------------------------------
// xcom_pkg
// Shared definitions for the XCOM transmit command queue:
//   - xq_state_e : handshake FSM states of xcom_tx_queue
//   - XCMD_SYNC  : header nibble hd[7:4] that marks a sync command
//   - xcmd_t     : one queued command {hd[7:0], dt[31:0]}
// ---------------------------------------------------------------------------
package xcom_pkg;

  typedef enum logic [1:0] {
    Q_IDLE = 2'd0,
    Q_REQ  = 2'd1,
    Q_DONE = 2'd2
  } xq_state_e;

  localparam logic [3:0] XCMD_SYNC = 4'b1000;

  typedef struct packed {
    logic [7:0]  hd;
    logic [31:0] dt;
  } xcmd_t;

  // Sync commands are passed through untouched; this only classifies them.
  function automatic logic xcmd_is_sync(input xcmd_t cmd);
    return cmd.hd[7:4] == XCMD_SYNC;
  endfunction

endpackage

// File: rtl/xcom_cmd_fifo.sv
// ---------------------------------------------------------------------------
// xcom_cmd_fifo
// 2^AW-entry command FIFO. Pointers are AW+1 bits wide so that full and
// empty fall out of a plain pointer compare. The storage array is not reset.
// Ports:
//   x_clk_i, x_rst_ni : clock, asynchronous active-low reset
//   push_i, wdata_i   : write strobe and command; ignored while full
//   pop_i             : advance the read pointer; ignored while empty
//   full_o, empty_o   : occupancy flags
//   level_o           : number of stored entries (0 .. 2^AW)
//   head_o            : entry at the read pointer
// ---------------------------------------------------------------------------
module xcom_cmd_fifo
  import xcom_pkg::*;
#(
  parameter int unsigned AW = 3
) (
  input  logic          x_clk_i,
  input  logic          x_rst_ni,
  input  logic          push_i,
  input  xcmd_t         wdata_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o,
  output xcmd_t         head_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  xcmd_t       mem_q [DEPTH];

  logic push_ok;
  logic pop_ok;

  // Same-wrap-bit equality means empty; opposite wrap bit with equal index
  // means the writer has lapped the reader exactly once.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level_o = wptr_q - rptr_q;
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge x_clk_i or negedge x_rst_ni) begin
    if (!x_rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge x_clk_i) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/xcom_tx_queue.sv
// ---------------------------------------------------------------------------
// xcom_tx_queue
// Command queue in front of the XCOM transmit command stage. Commands pushed
// from the control side are buffered in xcom_cmd_fifo and issued one at a
// time over the tx_req/tx_rdy handshake:
//   Q_IDLE -> Q_REQ  : queue not empty and link idle; head popped into tx_*_o
//   Q_REQ  -> Q_DONE : link accepted (tx_rdy_i low); req dropped
//   Q_DONE -> Q_IDLE : link finished (tx_rdy_i high); sent counter bumped
// A sync command keeps tx_rdy_i high while in Q_REQ, so req simply stays up.
// Ports:
//   x_clk_i, x_rst_ni          : clock, asynchronous active-low reset
//   c_push_i, c_hd_i, c_dt_i   : command push from the control side
//   c_clr_i                    : clear overflow flag and sent counter
//   c_full_o, c_ovf_o          : FIFO full, sticky push-while-full
//   q_empty_o, q_level_o       : FIFO empty, stored entries (excl. in flight)
//   sent_cnt_o                 : completed commands, modulo 2^CW
//   busy_o                     : FSM not in Q_IDLE
//   tx_req_o, tx_rdy_i         : handshake with the transmit command stage
//   tx_hd_o, tx_dt_o           : in-flight command
// ---------------------------------------------------------------------------
module xcom_tx_queue
  import xcom_pkg::*;
#(
  parameter int unsigned AW = 3,
  parameter int unsigned CW = 16
) (
  input  logic          x_clk_i,
  input  logic          x_rst_ni,
  input  logic          c_push_i,
  input  logic [7:0]    c_hd_i,
  input  logic [31:0]   c_dt_i,
  input  logic          c_clr_i,
  output logic          c_full_o,
  output logic          c_ovf_o,
  output logic          q_empty_o,
  output logic [AW:0]   q_level_o,
  output logic [CW-1:0] sent_cnt_o,
  output logic          busy_o,
  output logic          tx_req_o,
  input  logic          tx_rdy_i,
  output logic [7:0]    tx_hd_o,
  output logic [31:0]   tx_dt_o
);

  xq_state_e     state_q, state_d;
  logic          tx_req_q, tx_req_d;
  xcmd_t         tx_cmd_q, tx_cmd_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] sent_cnt_q, sent_cnt_d;

  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_level;
  xcmd_t         fifo_head;
  xcmd_t         push_cmd;
  logic          sent_inc;

  assign push_cmd = {c_hd_i, c_dt_i};

  xcom_cmd_fifo #(
    .AW (AW)
  ) u_fifo (
    .x_clk_i  (x_clk_i),
    .x_rst_ni (x_rst_ni),
    .push_i   (c_push_i),
    .wdata_i  (push_cmd),
    .pop_i    (fifo_pop),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .level_o  (fifo_level),
    .head_o   (fifo_head)
  );

  // Handshake FSM; the popped head is captured into tx_cmd_q on the same
  // edge that raises req, so the outputs only move on Q_IDLE -> Q_REQ.
  always_comb begin
    state_d  = state_q;
    tx_req_d = tx_req_q;
    tx_cmd_d = tx_cmd_q;
    fifo_pop = 1'b0;
    sent_inc = 1'b0;
    unique case (state_q)
      Q_IDLE: begin
        if (!fifo_empty && tx_rdy_i) begin
          fifo_pop = 1'b1;
          tx_cmd_d = fifo_head;
          tx_req_d = 1'b1;
          state_d  = Q_REQ;
        end
      end
      Q_REQ: begin
        if (!tx_rdy_i) begin
          tx_req_d = 1'b0;
          state_d  = Q_DONE;
        end
      end
      Q_DONE: begin
        if (tx_rdy_i) begin
          sent_inc = 1'b1;
          state_d  = Q_IDLE;
        end
      end
      default: begin
        tx_req_d = 1'b0;
        state_d  = Q_IDLE;
      end
    endcase
  end

  // Clear beats an increment, but a push-while-full in the clear cycle
  // still leaves the overflow flag set.
  always_comb begin
    ovf_d      = ovf_q;
    sent_cnt_d = sent_cnt_q;
    if (sent_inc) sent_cnt_d = sent_cnt_q + CW'(1);
    if (c_clr_i) begin
      ovf_d      = 1'b0;
      sent_cnt_d = '0;
    end
    if (c_push_i && fifo_full) ovf_d = 1'b1;
  end

  always_ff @(posedge x_clk_i or negedge x_rst_ni) begin
    if (!x_rst_ni) begin
      state_q    <= Q_IDLE;
      tx_req_q   <= 1'b0;
      tx_cmd_q   <= '0;
      ovf_q      <= 1'b0;
      sent_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_req_q   <= tx_req_d;
      tx_cmd_q   <= tx_cmd_d;
      ovf_q      <= ovf_d;
      sent_cnt_q <= sent_cnt_d;
    end
  end

  assign c_full_o   = fifo_full;
  assign c_ovf_o    = ovf_q;
  assign q_empty_o  = fifo_empty;
  assign q_level_o  = fifo_level;
  assign sent_cnt_o = sent_cnt_q;
  assign busy_o     = (state_q != Q_IDLE);
  assign tx_req_o   = tx_req_q;
  assign tx_hd_o    = tx_cmd_q.hd;
  assign tx_dt_o    = tx_cmd_q.dt;

endmodule

// File: tb/tb_xcom_tx_queue.sv
// ---------------------------------------------------------------------------
// tb_xcom_tx_queue
// Drives xcom_tx_queue (AW=3, CW=4) with directed and $urandom stimulus and
// compares every output each cycle against a transaction-level model: a
// queue of pending commands, the command currently on the link, and the
// link phase (offered / taken / none), plus the overflow flag and counter.
// ---------------------------------------------------------------------------
module tb_xcom_tx_queue;

  localparam int unsigned AW    = 3;
  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          c_push = 1'b0;
  logic [7:0]    c_hd = '0;
  logic [31:0]   c_dt = '0;
  logic          c_clr = 1'b0;
  logic          tx_rdy = 1'b0;
  logic          c_full_o;
  logic          c_ovf_o;
  logic          q_empty_o;
  logic [AW:0]   q_level_o;
  logic [CW-1:0] sent_cnt_o;
  logic          busy_o;
  logic          tx_req_o;
  logic [7:0]    tx_hd_o;
  logic [31:0]   tx_dt_o;

  xcom_tx_queue #(
    .AW (AW),
    .CW (CW)
  ) dut (
    .x_clk_i    (clk),
    .x_rst_ni   (rst_n),
    .c_push_i   (c_push),
    .c_hd_i     (c_hd),
    .c_dt_i     (c_dt),
    .c_clr_i    (c_clr),
    .c_full_o   (c_full_o),
    .c_ovf_o    (c_ovf_o),
    .q_empty_o  (q_empty_o),
    .q_level_o  (q_level_o),
    .sent_cnt_o (sent_cnt_o),
    .busy_o     (busy_o),
    .tx_req_o   (tx_req_o),
    .tx_rdy_i   (tx_rdy),
    .tx_hd_o    (tx_hd_o),
    .tx_dt_o    (tx_dt_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [39:0] mq[$];          // accepted, not yet issued
  logic [39:0] cur = '0;       // command presented on tx_hd/tx_dt
  int          link = 0;       // 0: nothing on link, 1: offered, 2: taken
  logic [3:0]  cnt_m = '0;
  logic        ovf_m = 1'b0;
  bit          chk_en = 1'b0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    cur   = '0;
    link  = 0;
    cnt_m = '0;
    ovf_m = 1'b0;
  endtask

  // Applies the rules for one clock edge given the inputs held this cycle.
  task automatic model_step();
    bit was_full;
    bit done;
    was_full = (mq.size() == DEPTH);
    done     = 1'b0;
    if (link == 0 && mq.size() != 0 && tx_rdy) begin
      cur  = mq.pop_front();
      link = 1;
    end else if (link == 1 && !tx_rdy) begin
      link = 2;
    end else if (link == 2 && tx_rdy) begin
      link = 0;
      done = 1'b1;
    end
    if (c_push) begin
      if (was_full) ovf_m = 1'b1;
      else          mq.push_back({c_hd, c_dt});
    end
    if (c_clr && !(c_push && was_full)) ovf_m = 1'b0;
    if (c_clr)     cnt_m = '0;
    else if (done) cnt_m = cnt_m + 4'd1;
  endtask

  task automatic compare_all();
    chk("req",   tx_req_o,   link == 1);
    chk("busy",  busy_o,     link != 0);
    chk("hd",    tx_hd_o,    cur[39:32]);
    chk("dt",    tx_dt_o,    cur[31:0]);
    chk("level", q_level_o,  64'(mq.size()));
    chk("empty", q_empty_o,  mq.size() == 0);
    chk("full",  c_full_o,   mq.size() == DEPTH);
    chk("ovf",   c_ovf_o,    ovf_m);
    chk("cnt",   sent_cnt_o, cnt_m);
  endtask

  // One clock: model follows the active edge, outputs checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    if (chk_en) compare_all();
  endtask

  task automatic push_cmd(input logic [7:0] hd, input logic [31:0] dt);
    c_push = 1'b1;
    c_hd   = hd;
    c_dt   = dt;
    tick();
    c_push = 1'b0;
  endtask

  task automatic wait_req(input int unsigned bound);
    int unsigned k = 0;
    tick();
    while (!tx_req_o && k < bound) begin
      tick();
      k++;
    end
    chk("req_wait", tx_req_o, 1'b1);
  endtask

  // Downstream side: link idle, take the offered command, finish later.
  task automatic serve(input bit chk_cmd, input logic [39:0] exp);
    tx_rdy = 1'b1;
    wait_req(20);
    if (chk_cmd) chk("order", {tx_hd_o, tx_dt_o}, exp);
    tx_rdy = 1'b0;
    repeat ($urandom_range(1, 4)) tick();
    tx_rdy = 1'b1;
  endtask

  logic [39:0] burst [DEPTH];
  logic [39:0] tmp;

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) tick();
    chk("rst_req",   tx_req_o,   1'b0);
    chk("rst_empty", q_empty_o,  1'b1);
    chk("rst_level", q_level_o,  '0);
    chk("rst_hd",    tx_hd_o,    '0);
    rst_n = 1'b1;
    tick();

    // Single command: req two cycles after the push
    tx_rdy = 1'b1;
    push_cmd(8'h21, 32'hDEADBEEF);
    chk("single_empty", q_empty_o, 1'b0);
    tick();
    chk("single_req", tx_req_o, 1'b1);
    chk("single_hd",  tx_hd_o,  8'h21);
    chk("single_dt",  tx_dt_o,  32'hDEADBEEF);
    tx_rdy = 1'b0;
    tick();
    chk("single_req_drop", tx_req_o, 1'b0);
    repeat (9) tick();
    tx_rdy = 1'b1;
    tick();
    chk("single_cnt", sent_cnt_o, 4'd1);

    // Burst of 8 with the link busy, 9th push overflows
    tx_rdy = 1'b0;
    c_clr  = 1'b1;
    tick();
    c_clr  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      burst[i] = {$urandom_range(0, 255), $urandom()};
      push_cmd(burst[i][39:32], burst[i][31:0]);
    end
    chk("burst_level", q_level_o, 4'd8);
    chk("burst_full",  c_full_o,  1'b1);
    chk("burst_ovf0",  c_ovf_o,   1'b0);
    push_cmd(8'hEE, 32'h0BAD_F00D);
    chk("burst_ovf1",   c_ovf_o,   1'b1);
    chk("burst_level9", q_level_o, 4'd8);
    for (int unsigned i = 0; i < DEPTH; i++) serve(1'b1, burst[i]);
    tick();
    chk("burst_cnt", sent_cnt_o, 4'd8);
    c_clr = 1'b1;
    tick();
    c_clr = 1'b0;
    chk("clr_ovf", c_ovf_o, 1'b0);
    chk("clr_cnt", sent_cnt_o, 4'd0);

    // Sync command: link keeps rdy high, req must hold
    tx_rdy = 1'b1;
    tmp = {8'h80, $urandom()};
    push_cmd(tmp[39:32], tmp[31:0]);
    wait_req(10);
    repeat (50) begin
      tick();
      chk("sync_hold", {tx_req_o, tx_hd_o, tx_dt_o}, {1'b1, tmp});
    end
    tx_rdy = 1'b0;
    tick();
    tx_rdy = 1'b1;
    tick();
    chk("sync_cnt", sent_cnt_o, 4'd1);

    // Push and pop in the same cycle at level 3, then clear racing an increment
    tx_rdy = 1'b0;
    repeat (3) push_cmd($urandom_range(0, 255), $urandom());
    chk("pp_level3", q_level_o, 4'd3);
    tx_rdy = 1'b1;
    push_cmd($urandom_range(0, 255), $urandom());
    chk("pp_level", q_level_o, 4'd3);
    chk("pp_req",   tx_req_o,  1'b1);
    tx_rdy = 1'b0;
    repeat (2) tick();
    tx_rdy = 1'b1;
    c_clr  = 1'b1;
    tick();
    c_clr  = 1'b0;
    chk("clr_vs_inc", sent_cnt_o, 4'd0);
    repeat (3) serve(1'b0, '0);
    tick();

    // Random traffic with a randomly behaving link
    for (int unsigned i = 0; i < 300; i++) begin
      c_push = ($urandom_range(0, 1) == 1);
      c_hd   = $urandom_range(0, 255);
      c_dt   = $urandom();
      c_clr  = ($urandom_range(0, 19) == 0);
      tx_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    c_push = 1'b0;
    c_clr  = 1'b0;
    for (int unsigned k = 0; k < 300 && !(q_empty_o && !busy_o); k++) begin
      tx_rdy = !tx_req_o;
      tick();
    end
    chk("drain_empty", q_empty_o, 1'b1);
    chk("drain_busy",  busy_o,    1'b0);

    // Reset while a command is offered and 4 more are queued
    tx_rdy = 1'b0;
    repeat (5) push_cmd($urandom_range(0, 255), $urandom());
    tx_rdy = 1'b1;
    wait_req(10);
    chk("prerst_level", q_level_o, 4'd4);
    @(posedge clk);
    model_step();
    #3 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all();
    chk("midrst_req",   tx_req_o,  1'b0);
    chk("midrst_empty", q_empty_o, 1'b1);
    chk("midrst_level", q_level_o, '0);
    rst_n = 1'b1;
    repeat (20) begin
      tick();
      chk("postrst_noreq", tx_req_o, 1'b0);
    end

    // Counter wrap: 16 completions bring a 4-bit counter back to 0
    for (int unsigned i = 0; i < 16; i++) begin
      push_cmd($urandom_range(0, 255), $urandom());
      serve(1'b0, '0);
      tick();
      chk("wrap_cnt", sent_cnt_o, 64'((i + 1) % 16));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xcom_tx_queue.md
# xcom_tx_queue

Command queue in front of the XCOM transmit command stage. It buffers {header, data} commands pushed from the control side in a 2^AW-entry FIFO. It issues them one at a time over the tx_req/tx_rdy handshake to the transmit command stage, which drives tx_req_i/tx_rdy_o/tx_hd_i/tx_dt_i. Status outputs are an occupancy level, a sticky overflow flag and a sent-command counter. Single clock domain (x_clk_i).

## Interface
- AW, 3, FIFO address width; depth = 2^AW entries of 40 bits ({hd[7:0], dt[31:0]}).
- CW, 16, width of the sent-command counter.

Ports:
- x_clk_i  in  1  clock.
- x_rst_ni  in  1  reset, asynchronous, active-low.
- c_push_i  in  1  push one command; single-cycle strobe, one command per cycle max.
- c_hd_i  in  8  command header (hd[7:4]==4'b1000 is a sync command; passed through untouched).
- c_dt_i  in  32  command data.
- c_clr_i  in  1  synchronous clear of c_ovf_o and sent_cnt_o; does not touch FIFO contents.
- c_full_o  out  1  FIFO full (level == 2^AW).
- c_ovf_o  out  1  sticky: a push arrived while full.
- q_empty_o  out  1  FIFO empty.
- q_level_o  out  AW+1  entries currently stored, excluding the one in flight.
- sent_cnt_o  out  CW  completed commands, wraps modulo 2^CW.
- busy_o  out  1  FSM not in Q_IDLE.
- tx_req_o  out  1  request to transmit command stage.
- tx_rdy_i  in  1  ready from transmit command stage (high = link idle).
- tx_hd_o  out  8  header of in-flight command.
- tx_dt_o  out  32  data of in-flight command.

## Operation
- FIFO: registered write/read pointers of AW+1 bits; full/empty come from pointer compare. Storage is a plain register array; no reset on the array.
- A push is accepted iff c_full_o==0 in that cycle. A push while full is dropped and sets c_ovf_o. A push and a pop in the same cycle with the FIFO not full are both accepted; level stays unchanged.
- FSM states: Q_IDLE, Q_REQ, Q_DONE.
  - Q_IDLE: if !q_empty_o & tx_rdy_i, then pop the head into the tx_hd_o/tx_dt_o registers, set tx_req_o, and go to Q_REQ.
  - Q_REQ: hold tx_req_o=1 and the outputs stable. When tx_rdy_i==0 (command accepted by the link), clear tx_req_o and go to Q_DONE.
  - Q_DONE: tx_req_o=0. When tx_rdy_i==1 (link finished), increment sent_cnt_o and go to Q_IDLE.
- Sync commands: the downstream stage keeps tx_rdy high while waiting for its pulse. The FSM therefore stays in Q_REQ indefinitely with req held. There is no timeout.
- tx_hd_o and tx_dt_o change only on Q_IDLE->Q_REQ and stay stable through Q_REQ and Q_DONE.
- c_clr_i and an increment in the same cycle: clear wins, so the counter becomes 0.
- c_clr_i and a push-while-full in the same cycle: c_ovf_o ends at 1 (set wins).

## Timing
- Reset values: tx_req_o=0, tx_hd_o=0, tx_dt_o=0, c_full_o=0, c_ovf_o=0, q_empty_o=1, q_level_o=0, sent_cnt_o=0, busy_o=0. FSM=Q_IDLE, pointers=0.
- All outputs are registered.
- Push-to-req latency on an idle, empty queue is 2 cycles:
  - push at cycle N;
  - q_empty_o=0 at N+1;
  - tx_req_o=1 at N+2.
- Req drops 1 cycle after tx_rdy_i is sampled low. The next req rises no earlier than 2 cycles after tx_rdy_i is sampled high (Q_DONE->Q_IDLE->Q_REQ).
- q_level_o updates the cycle after the push or pop.
- sent_cnt_o updates the cycle after the Q_DONE exit.
- Reset mid-operation drops req immediately and discards queued and in-flight commands. The downstream stage shares x_rst_ni, so both sides return to idle together.

## Structure
- Shared package xcom_pkg holds:
  - typedef of the FSM state enum (Q_IDLE, Q_REQ, Q_DONE);
  - constant XCMD_SYNC = 4'b1000;
  - packed struct for a command {hd[7:0], dt[31:0]}.
- One sub-module: xcom_cmd_fifo (parameter AW). It provides push/pop, full/empty/level and head data, and carries no handshake logic. The FSM, counters and flags live in xcom_tx_queue.

## Test plan
- Single command: push hd=8'h21, dt=32'hDEADBEEF with tx_rdy_i=1; a model drops rdy 1 cycle after req and raises it 10 cycles later.
  - Expect req at push+2, tx_hd_o=8'h21, tx_dt_o=32'hDEADBEEF.
  - Expect req low 1 cycle after rdy falls, then sent_cnt_o=1.
- Burst of 8 pushes (AW=3) back-to-back while rdy is held low: level reaches 8 and c_full_o=1. A 9th push sets c_ovf_o=1 and leaves level at 8. Release rdy: all 8 commands go out in push order and sent_cnt_o=8.
- Sync command hd=8'h80 with rdy held high for 50 cycles: tx_req_o stays 1 with outputs stable for 50 cycles. Then drop and raise rdy; the FSM completes and sent_cnt_o increments once.
- Same-cycle push and pop at level 3: level stays 3. Then assert c_clr_i in the same cycle as a sent_cnt increment: sent_cnt_o=0.
- Assert x_rst_ni low while in Q_REQ with 4 entries queued: next cycle tx_req_o=0, q_empty_o=1, q_level_o=0. No further req occurs after reset releases.
- Counter wrap with CW=4: 16 completed commands bring sent_cnt_o back to 0.
